reg_bus_master: RTL and testbench

Bus initiator for the shared 8-bit bidirectional register bus (Sel / RnW / Dio).
- Accepts single read or write requests on a valid/ready interface.
- Decodes the address to a one-hot Sel line.
- Drives Dio for writes, tristates and samples Dio for reads, and returns read data with a one-cycle response strobe.
- Sits between a sequencer or CPU-like front end and a bank of NREG bus registers.

---
 rtl/reg_bus_pkg.sv | 14 +
 rtl/reg_bus_sel_dec.sv | 24 ++
 rtl/reg_bus_master.sv | 117 +++++++++++
 tb/tb_reg_bus_master.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared types and constants for the 8-bit register bus
package reg_bus_pkg;

  localparam int   DATA_W       = 8;
  localparam logic BUS_IDLE_RNW = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } bus_state_e;

endpackage

// File: rtl/reg_bus_sel_dec.sv
// rtl/reg_bus_sel_dec.sv - address to one-hot register select decoder with in-range flag
module reg_bus_sel_dec #(
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic [AW-1:0] i_addr,
  output logic [N-1:0]  o_sel,
  output logic          o_in_range
);

  // One-hot decode; an address at or above N leaves every select low
  always_comb begin
    o_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (i_addr == AW'(i)) begin
        o_sel[i] = 1'b1;
      end
    end
  end

  // Exactly the addresses that light a select line are in range
  assign o_in_range = |o_sel;

endmodule

// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - single-request initiator for the shared Sel/RnW/Dio register bus
// Optional out-of-range error strobe RspErr enabled by defining REG_BUS_ERR_EN.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic              Clk,
  input  logic              nRst,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWr,
  input  logic [AW-1:0]     ReqAddr,
  input  logic [DATA_W-1:0] ReqData,
  output logic              RspValid,
  output logic [DATA_W-1:0] RspData,
  output logic              Busy,
  output logic [NREG-1:0]   Sel,
  output logic              RnW,
  inout  wire  [DATA_W-1:0] Dio
`ifdef REG_BUS_ERR_EN
  ,
  output logic              RspErr
`endif
);

  bus_state_e        r_state;
  bus_state_e        w_state_nxt;
  logic [NREG-1:0]   r_sel;
  logic              r_rnw;
  logic [DATA_W-1:0] r_wdata;
  logic              r_in_range;
  logic [DATA_W-1:0] r_rsp_data;
  logic [NREG-1:0]   w_dec_sel;
  logic              w_dec_in_range;
  logic              w_accept;

  reg_bus_sel_dec #(
    .N  (NREG),
    .AW (AW)
  ) u_sel_dec (
    .i_addr     (ReqAddr),
    .o_sel      (w_dec_sel),
    .o_in_range (w_dec_in_range)
  );

  assign w_accept = ReqValid && (r_state == IDLE);

  // Phase sequencing: write is one bus beat, read is one beat plus a turnaround guard
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = ReqWr ? WRITE : READ;
        end
      end
      WRITE:   w_state_nxt = IDLE;
      READ:    w_state_nxt = TURN;
      TURN:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset drops any transaction in flight
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus phase registers: loaded at acceptance, released on the edge closing the beat
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      r_sel      <= '0;
      r_rnw      <= BUS_IDLE_RNW;
      r_wdata    <= '0;
      r_in_range <= 1'b0;
    end else if (w_accept) begin
      r_sel      <= w_dec_sel;
      r_rnw      <= ReqWr ? 1'b0 : BUS_IDLE_RNW;
      r_wdata    <= ReqData;
      r_in_range <= w_dec_in_range;
    end else begin
      r_sel <= '0;
      r_rnw <= BUS_IDLE_RNW;
    end
  end

  // Read data capture; an unselected bus floats, so out-of-range reads return zero
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      r_rsp_data <= '0;
    end else if (r_state == READ) begin
      r_rsp_data <= r_in_range ? Dio : '0;
    end
  end

  // Master owns Dio only during the write beat, when RnW is low
  assign Dio = (r_state == WRITE) ? r_wdata : {DATA_W{1'bz}};

  assign Sel      = r_sel;
  assign RnW      = r_rnw;
  assign ReqReady = (r_state == IDLE);
  assign Busy     = (r_state != IDLE);
  assign RspValid = (r_state == TURN);
  assign RspData  = r_rsp_data;

`ifdef REG_BUS_ERR_EN
  // Error strobe lines up with the write beat or the read response cycle
  assign RspErr = !r_in_range && ((r_state == WRITE) || (r_state == TURN));
`endif

endmodule

// File: tb/tb_reg_bus_master.sv
// tb/tb_reg_bus_master.sv - self-checking bench for reg_bus_master with four bus-register slaves
module tb_reg_bus_master;

  localparam int NREG = 4;
  localparam int AW   = 3;
  localparam int NCYC = 4096;

  logic            Clk      = 1'b0;
  logic            nRst     = 1'b0;
  logic            ReqValid = 1'b0;
  logic            ReqWr    = 1'b0;
  logic [AW-1:0]   ReqAddr  = '0;
  logic [7:0]      ReqData  = '0;
  logic            ReqReady;
  logic            RspValid;
  logic [7:0]      RspData;
  logic            Busy;
  logic [NREG-1:0] Sel;
  logic            RnW;
  wire  [7:0]      Dio;
`ifdef REG_BUS_ERR_EN
  logic            RspErr;
`endif

  int n_run  = 0;
  int n_fail = 0;

  reg_bus_master #(
    .NREG (NREG),
    .AW   (AW)
  ) u_dut (
    .Clk      (Clk),
    .nRst     (nRst),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .ReqWr    (ReqWr),
    .ReqAddr  (ReqAddr),
    .ReqData  (ReqData),
    .RspValid (RspValid),
    .RspData  (RspData),
    .Busy     (Busy),
    .Sel      (Sel),
    .RnW      (RnW),
    .Dio      (Dio)
`ifdef REG_BUS_ERR_EN
    ,
    .RspErr   (RspErr)
`endif
  );

  initial forever #5 Clk = ~Clk;

  // Slaves: selected register drives on reads; otherwise a noise pattern stands in for a floating bus
  logic [7:0] s_mem [NREG];
  logic [7:0] s_drv;
  always_comb begin
    s_drv = 8'hC3;
    for (int i = 0; i < NREG; i++) begin
      if (Sel[i]) s_drv = s_mem[i];
    end
  end
  assign Dio = RnW ? s_drv : 8'hzz;

  initial begin
    for (int i = 0; i < NREG; i++) s_mem[i] = 8'h00;
    forever begin
      @(posedge Clk);
      if (nRst && !RnW) begin
        for (int i = 0; i < NREG; i++) begin
          if (Sel[i]) s_mem[i] = Dio;
        end
      end
    end
  end

  // Expected-output timeline: one slot per clock interval
  logic [NREG-1:0] e_sel  [NCYC];
  bit              e_wr   [NCYC];
  bit              e_dio  [NCYC];
  bit              e_rspv [NCYC];
  bit              e_err  [NCYC];
  logic [7:0]      e_data [NCYC];
  int              e_addr [NCYC];
  logic [7:0]      m_mem  [NREG];
  int cyc       = 0;
  int m_free_at = 0;
  int m_acc_cnt = 0;
  int m_acc_cyc = 0;

  task automatic clear_slot(input int k);
    e_sel[k] = '0; e_wr[k] = 0; e_dio[k] = 0; e_rspv[k] = 0; e_err[k] = 0;
    e_data[k] = 8'h00; e_addr[k] = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model: a write occupies the next interval; a read's data appears two intervals after acceptance
  initial begin
    int  a;
    bit  inr;
    for (int k = 0; k < NCYC; k++) clear_slot(k);
    for (int i = 0; i < NREG; i++) m_mem[i] = 8'h00;
    forever begin
      @(posedge Clk);
      if (cyc < NCYC - 4) begin
        if (!nRst) begin
          for (int k = cyc; k < cyc + 4; k++) clear_slot(k);
          m_free_at = cyc + 1;
        end else begin
          if (e_wr[cyc] && e_dio[cyc]) m_mem[e_addr[cyc]] = e_data[cyc];
          if (ReqValid && cyc >= m_free_at) begin
            a   = int'(ReqAddr);
            inr = (a < NREG);
            m_acc_cnt++;
            m_acc_cyc = cyc;
            e_sel[cyc+1] = inr ? (NREG'(1) << a) : '0;
            if (ReqWr) begin
              e_wr[cyc+1]   = 1;
              e_dio[cyc+1]  = inr;
              e_data[cyc+1] = ReqData;
              e_addr[cyc+1] = a;
              e_err[cyc+1]  = !inr;
              m_free_at     = cyc + 2;
            end else begin
              e_rspv[cyc+2] = 1;
              e_data[cyc+2] = inr ? m_mem[a] : 8'h00;
              e_err[cyc+2]  = !inr;
              m_free_at     = cyc + 3;
            end
          end
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison against the model, mid-cycle
  initial begin
    logic [7:0] hold;
    hold = 8'h00;
    forever begin
      @(negedge Clk);
      if (!nRst) begin
        hold = 8'h00;
        chk("rst_ready", ReqReady, 1);
        chk("rst_busy", Busy, 0);
        chk("rst_sel", Sel, 0);
        chk("rst_rnw", RnW, 1);
        chk("rst_rspv", RspValid, 0);
        chk("rst_rspd", RspData, 8'h00);
`ifdef REG_BUS_ERR_EN
        chk("rst_err", RspErr, 0);
`endif
      end else begin
        if (e_rspv[cyc]) hold = e_data[cyc];
        chk("ready", ReqReady, cyc >= m_free_at);
        chk("busy", Busy, cyc < m_free_at);
        chk("sel", Sel, e_sel[cyc]);
        chk("rnw", RnW, !e_wr[cyc]);
        chk("rspv", RspValid, e_rspv[cyc]);
        chk("rspd", RspData, hold);
        if (e_dio[cyc]) chk("dio_wr", Dio, e_data[cyc]);
`ifdef REG_BUS_ERR_EN
        chk("err", RspErr, e_err[cyc]);
`endif
      end
      if (RnW) chk("contention", Dio, s_drv);
    end
  end

  task automatic wait_acc(output int waited);
    int c0;
    c0     = m_acc_cnt;
    waited = 0;
    while (m_acc_cnt == c0 && waited < 20) begin
      @(posedge Clk); #1;
      waited++;
    end
    if (m_acc_cnt == c0) begin
      n_run++;
      n_fail++;
      $display("FAIL accept_timeout cycle %0d: got no acceptance, want one within 20 cycles", cyc);
    end
  endtask

  task automatic do_req(input bit wr, input int addr, input logic [7:0] data, output int waited);
    ReqValid = 1'b1;
    ReqWr    = wr;
    ReqAddr  = AW'(addr);
    ReqData  = data;
    wait_acc(waited);
  endtask

  initial begin
    int w;
    int lat;
    int prev;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("init_sel", Sel, 0);
    chk("init_rnw", RnW, 1);
    chk("init_ready", ReqReady, 1);
    @(posedge Clk); #3 nRst = 1'b1;
    @(posedge Clk); #1;

    // Write A5 to register 2, then read it back
    do_req(1, 2, 8'hA5, w);
    ReqValid = 1'b0;
    chk("wr_sel", Sel, 4'b0100);
    chk("wr_rnw", RnW, 0);
    chk("wr_dio", Dio, 8'hA5);
    @(posedge Clk); #1;
    do_req(0, 2, 8'h00, w);
    ReqValid = 1'b0;
    chk("rd_sel", Sel, 4'b0100);
    lat = 1;  // edges counted from the accepting edge
    while (!RspValid && lat < 8) begin
      @(posedge Clk); #1;
      lat++;
    end
    chk("rd_latency", lat, 2);
    chk("rd_data", RspData, 8'hA5);

    // Back-to-back writes then reads across all four registers
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      do_req(1, i, 8'(17 * (i + 1)), w);
      if (i > 0) chk("b2b_wr_gap", m_acc_cyc - prev, 2);
      prev = m_acc_cyc;
    end
    for (int i = 0; i < 4; i++) begin
      do_req(0, i, 8'h00, w);
      chk("b2b_rd_gap", m_acc_cyc - prev, (i == 0) ? 2 : 3);
      prev = m_acc_cyc;
    end
    ReqValid = 1'b0;
    repeat (3) @(posedge Clk); #1;
    chk("b2b_last", RspData, 8'h44);
    for (int i = 0; i < 4; i++) chk("b2b_mem", s_mem[i], 8'(17 * (i + 1)));

    // Out-of-range write and read
    do_req(1, 5, 8'hFF, w);
    ReqValid = 1'b0;
    chk("oor_wr_sel", Sel, 0);
    @(posedge Clk); #1;
    do_req(0, 5, 8'h00, w);
    ReqValid = 1'b0;
    chk("oor_rd_sel", Sel, 0);
    @(posedge Clk); #1;
    chk("oor_rspv", RspValid, 1);
    chk("oor_rspd", RspData, 8'h00);
    for (int i = 0; i < 4; i++) chk("oor_mem", s_mem[i], 8'(17 * (i + 1)));

    // Request held during busy with changing data; only the accepted data lands
    do_req(1, 1, 8'h5A, w);
    ReqData = 8'hEE;
    @(posedge Clk); #1;
    ReqAddr = AW'(3);
    ReqData = 8'h77;
    wait_acc(w);
    chk("stall_wait", w, 1);
    ReqValid = 1'b0;
    @(posedge Clk); #1;
    chk("stall_mem1", s_mem[1], 8'h5A);
    chk("stall_mem3", s_mem[3], 8'h77);

    // Reset in the middle of a write beat
    do_req(1, 0, 8'h99, w);
    ReqValid = 1'b0;
    chk("mid_sel", Sel, 4'b0001);
    #1 nRst = 1'b0;
    #1;
    chk("async_sel", Sel, 0);
    chk("async_rnw", RnW, 1);
    chk("async_busy", Busy, 0);
    @(posedge Clk);
    @(posedge Clk); #3 nRst = 1'b1;
    @(posedge Clk); #1;
    chk("rst_lost_wr", s_mem[0], 8'h11);
    do_req(0, 0, 8'h00, w);
    ReqValid = 1'b0;
    @(posedge Clk); #1;
    chk("post_rst_rd", RspData, 8'h11);

    repeat (3) @(posedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

endmodule
